// File: rtl/axi_burst_ptgen_if.sv
// axi_burst_ptgen_if: AXI4 master bus bundle driven by the burst pattern generator
interface axi_burst_ptgen_if #(parameter int DATA_W = 32);
  logic [31:0]         M_AXI_AWADDR;
  logic [7:0]          M_AXI_AWLEN;
  logic [2:0]          M_AXI_AWSIZE;
  logic [1:0]          M_AXI_AWBURST;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WLAST;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [31:0]         M_AXI_ARADDR;
  logic [7:0]          M_AXI_ARLEN;
  logic [2:0]          M_AXI_ARSIZE;
  logic [1:0]          M_AXI_ARBURST;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RLAST;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;
  modport master (
    output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    output M_AXI_RREADY
  );
  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_burst_ptgen.sv
// axi_burst_ptgen: AXI4 burst traffic generator writing an incrementing pattern and reading it back for checking
module axi_burst_ptgen #(
  parameter int DATA_W     = 32,
  parameter int BURST_LEN  = 16,
  parameter int NUM_BURSTS = 4,
  parameter int MODE       = 2
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              INIT_AXI_TXN,
  input  logic [31:0]       BASE_ADDR,
  output logic              TXN_DONE,
  output logic              ERROR,
  output logic [15:0]       ERR_CNT,
  axi_burst_ptgen_if.master m_axi
);
  localparam int BYTES = BURST_LEN * (DATA_W / 8);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int NW = $clog2(NUM_BURSTS + 1);
  if (BYTES > 4096 || !(DATA_W inside {32, 64, 128}) || BURST_LEN < 1 || BURST_LEN > 256 ||
      NUM_BURSTS < 1 || NUM_BURSTS > 1024 || MODE < 0 || MODE > 2) begin : g_bad_params
    $error("axi_burst_ptgen: illegal parameters (burst must fit in 4 KiB)");
  end
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
  state_t state, state_n;
  logic init_q, start, beat_last, burst_last, w_hs, b_hs, r_hs, err_ev;
  logic [31:0] base, addr, g;
  logic [BW-1:0] beat;
  logic [NW-1:0] burst;
  always_comb begin
    start = INIT_AXI_TXN && !init_q && (state == IDLE || state == DONE);
    beat_last = beat == BW'(BURST_LEN - 1);
    burst_last = burst == NW'(NUM_BURSTS - 1);
    w_hs = state == WR_DATA && m_axi.M_AXI_WREADY;
    b_hs = state == WR_RESP && m_axi.M_AXI_BVALID;
    r_hs = state == RD_DATA && m_axi.M_AXI_RVALID;
    // several causes on the same beat collapse into one event
    err_ev = (b_hs && m_axi.M_AXI_BRESP inside {2'b10, 2'b11}) ||
             (r_hs && (m_axi.M_AXI_RRESP inside {2'b10, 2'b11} || m_axi.M_AXI_RLAST != beat_last ||
                       (MODE == 2 && m_axi.M_AXI_RDATA != DATA_W'(g))));
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? (MODE == 1 ? RD_ADDR : WR_ADDR) : state;
      WR_ADDR:    state_n = m_axi.M_AXI_AWREADY ? WR_DATA : WR_ADDR;
      WR_DATA:    state_n = w_hs && beat_last ? WR_RESP : WR_DATA;
      WR_RESP:    state_n = !b_hs ? WR_RESP : !burst_last ? WR_ADDR : MODE == 2 ? RD_ADDR : DONE;
      RD_ADDR:    state_n = m_axi.M_AXI_ARREADY ? RD_DATA : RD_ADDR;
      RD_DATA:    state_n = !(r_hs && beat_last) ? RD_DATA : burst_last ? DONE : RD_ADDR;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state   <= IDLE;
      init_q  <= 1'b1;
      base    <= '0;
      addr    <= '0;
      g       <= '0;
      beat    <= '0;
      burst   <= '0;
      ERROR   <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      state  <= state_n;
      init_q <= INIT_AXI_TXN;
      if (start) begin
        base    <= BASE_ADDR;
        addr    <= BASE_ADDR;
        g       <= '0;
        beat    <= '0;
        burst   <= '0;
        ERROR   <= 1'b0;
        ERR_CNT <= '0;
      end
      if (w_hs || r_hs) begin
        g    <= g + 32'd1;
        beat <= beat_last ? '0 : beat + 1'b1;
      end
      if (b_hs || (r_hs && beat_last)) begin
        burst <= burst_last ? '0 : burst + 1'b1;
        addr  <= burst_last ? base : addr + 32'(BYTES);
      end
      // read-back pattern restarts from zero
      if (b_hs && burst_last) g <= '0;
      if (err_ev) begin
        ERROR   <= 1'b1;
        ERR_CNT <= ERR_CNT + {15'd0, ERR_CNT != 16'hFFFF};
      end
    end
  assign TXN_DONE             = state == DONE;
  assign m_axi.M_AXI_AWADDR   = addr;
  assign m_axi.M_AXI_AWLEN    = 8'(BURST_LEN - 1);
  assign m_axi.M_AXI_AWSIZE   = 3'($clog2(DATA_W / 8));
  assign m_axi.M_AXI_AWBURST  = 2'b01;
  assign m_axi.M_AXI_AWVALID  = state == WR_ADDR;
  assign m_axi.M_AXI_WDATA    = DATA_W'(g);
  assign m_axi.M_AXI_WSTRB    = '1;
  assign m_axi.M_AXI_WLAST    = state == WR_DATA && beat_last;
  assign m_axi.M_AXI_WVALID   = state == WR_DATA;
  assign m_axi.M_AXI_BREADY   = state == WR_RESP;
  assign m_axi.M_AXI_ARADDR   = addr;
  assign m_axi.M_AXI_ARLEN    = 8'(BURST_LEN - 1);
  assign m_axi.M_AXI_ARSIZE   = 3'($clog2(DATA_W / 8));
  assign m_axi.M_AXI_ARBURST  = 2'b01;
  assign m_axi.M_AXI_ARVALID  = state == RD_ADDR;
  assign m_axi.M_AXI_RREADY   = state == RD_DATA;
endmodule
